inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter DIV_MAX, default 100_000_000: free-run advance period in clk cycles (1 Hz at 100 MHz).
REQ-002 Parameter DEB_MAX, default 1_000_000: cycles step_btn must be stable before the debounced level changes.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: first fetch address.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 step_mode  in  1  1 = advance only on a step pulse; 0 = advance on divider tick.
REQ-007 step_btn  in  1  raw, bouncing pushbutton.
REQ-008 pc_src  in  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 treated as 00.
REQ-009 br_imm  in  16  branch offset in words, signed.
REQ-010 j_idx  in  26  jump word index.
REQ-011 mem_addr  out  32  instruction memory address.
REQ-012 mem_en  out  1  instruction memory read enable; the memory returns data one cycle later.
REQ-013 mem_data  in  32  instruction memory read data.
REQ-014 pc  out  32  address of the held instruction.
REQ-015 inst  out  32  held instruction.
REQ-016 inst_valid  out  1  inst and pc are coherent and stable.

Function
REQ-017 States: BOOT, REQ, LATCH and HOLD.
- BOOT->REQ unconditionally.
- REQ->LATCH unconditionally.
- LATCH->HOLD unconditionally; inst<=mem_data and inst_valid<=1 on that edge.
- HOLD->REQ on an advance event; pc<=next_pc and inst_valid<=0 on that edge.
REQ-018 mem_en = 1 only in REQ; mem_addr = pc in every state.
REQ-019 Latency: rst release to inst_valid = 3 rising edges; HOLD advance edge to inst_valid = 2 further edges.
REQ-020 Advance event:
- step_mode=0: divider tick only.
- step_mode=1: debounced step pulse only.
- The mode is sampled each cycle.
REQ-021 Divider: counter runs 0..DIV_MAX-1 in every state; tick is 1 for exactly the cycle with count==DIV_MAX-1.
REQ-022 A tick or step pulse outside HOLD shall be dropped, never queued.
REQ-023 Debounce: step_btn passes a 2-FF synchronizer, then a stability counter; the debounced level changes after DEB_MAX consecutive equal samples; its 0->1 edge yields a one-cycle step pulse.
REQ-024 next_pc is computed from pc_src, br_imm and j_idx as sampled on the advance edge:
- seq = pc+4.
- branch = pc+4+(sext(br_imm)<<2).
- jump = {seq[31:28], j_idx, 2'b00}.
- All sums are modulo 2^32 (0xFFFF_FFFC + 4 = 0).
REQ-025 inst and pc shall not change while inst_valid=1.

Reset
REQ-026 While rst=0, immediately and regardless of clk:
- state=BOOT, pc=RESET_PC, inst=0, inst_valid=0, mem_en=0.
- Divider count=0, debouncer counter=0, debounced level=0, synchronizer=0.
REQ-027 Reset asserted in any state, including mid-fetch in REQ or LATCH, aborts the fetch; the refetch after release starts at RESET_PC.

Structure
REQ-028 Shared package holds: pc_src encodings (PC_SEQ, PC_BR, PC_J), state encoding, the RESET_PC default and the instruction width (32).
REQ-029 One sub-module, btn_debounce (synchronizer, stability counter, rising-edge pulse), parameterised by DEB_MAX; divider and FSM live in inst_fetch.

Verification (DIV_MAX=4, DEB_MAX=3; memory model: 1-cycle read, data = addr ^ 32'hA5A5_0000)
REQ-030 Reset release, step_mode=0:
- mem_en=1 with mem_addr=0 in cycle 1.
- inst_valid=1 with inst=0xA5A5_0000 after edge 3.
REQ-031 Free run, pc_src=00: pc steps 0,4,8,… one per tick (every 4 cycles); pc=0xFFFF_FFFC advances to 0.
REQ-032 Branch at pc=0x10 with pc_src=01, br_imm=0xFFFC -> pc=0x04, inst=0xA5A5_0004.
REQ-033 Jump at pc=0x8000_0010 with pc_src=10, j_idx=26'h40 -> pc=0x8000_0100.
REQ-034 Step mode, both events checked:
- step_btn glitches of 2 cycles -> no advance.
- step_btn held 6 cycles -> exactly one advance; ticks meanwhile are ignored.
REQ-035 rst=0 asserted during REQ of the third fetch:
- Outputs reach their reset values without a clk edge.
- After release the next fetch is at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select codes,
// FSM state encoding, default boot address and next-PC arithmetic.
package inst_fetch_pkg;

    localparam int          INST_W       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // next-PC select codes; 2'b11 falls through to sequential
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        REQ   = 2'b01,
        LATCH = 2'b10,
        HOLD  = 2'b11
    } fetch_state_e;

    // All sums wrap modulo 2^32; branch offset is a signed word count.
    function automatic logic [31:0] calc_next_pc(
        input logic [31:0] cur_pc,
        input logic [1:0]  src,
        input logic [15:0] imm,
        input logic [25:0] idx
    );
        logic [31:0] seq;
        seq = cur_pc + 32'd4;
        case (src)
            PC_BR:   return seq + {{14{imm[15]}}, imm, 2'b00};
            PC_J:    return {seq[31:28], idx, 2'b00};
            default: return seq;
        endcase
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory bus: address/enable out of the fetch unit, read data
// back one cycle after an enabled request.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic [31:0]       mem_addr;
    logic              mem_en;
    logic [INST_W-1:0] mem_data;

    modport master (output mem_addr, output mem_en, input  mem_data);
    modport slave  (input  mem_addr, input  mem_en, output mem_data);

endinterface

// File: rtl/inst_fetch_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEB_MAX = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(DEB_MAX + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;

    // bring the raw button into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= 2'b00;
        else      sync <= {sync[0], btn};
    end

    // level follows the input only after DEB_MAX consecutive differing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_MAX - 1)) begin
                cnt   <= '0;
                level <= sync[1];
                pulse <= sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Single-instruction fetch unit: fetches one word, holds it with a valid
// flag, and moves on only on a divider tick or a debounced step press.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          DIV_MAX  = 100_000_000,
    parameter int          DEB_MAX  = 1_000_000,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_mode,
    input  logic              step_btn,
    input  logic [1:0]        pc_src,
    input  logic [15:0]       br_imm,
    input  logic [25:0]       j_idx,
    inst_fetch_if.master      mem,
    output logic [31:0]       pc,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid
);
    localparam int DIV_W = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    fetch_state_e state;
    logic [DIV_W-1:0] div_cnt;
    logic tick, step_pulse, advance, mem_en;

    assign tick    = (div_cnt == DIV_W'(DIV_MAX - 1));
    // events arriving outside HOLD are simply not looked at, so never queue
    assign advance = step_mode ? step_pulse : tick;

    assign mem.mem_addr = pc;
    assign mem.mem_en   = mem_en;

    btn_debounce #(.DEB_MAX(DEB_MAX)) u_deb (
        .clk   (clk),
        .rst   (rst),
        .btn   (step_btn),
        .pulse (step_pulse)
    );

    // free-running period divider, independent of fetch state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

    // fetch sequencer; mem_en is registered so it is high exactly in REQ
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_valid <= 1'b0;
            mem_en     <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state  <= REQ;
                    mem_en <= 1'b1;
                end
                REQ: begin
                    state  <= LATCH;
                    mem_en <= 1'b0;
                end
                LATCH: begin
                    state      <= HOLD;
                    inst       <= mem.mem_data;
                    inst_valid <= 1'b1;
                end
                HOLD: begin
                    if (advance) begin
                        state      <= REQ;
                        pc         <= calc_next_pc(pc, pc_src, br_imm, j_idx);
                        inst_valid <= 1'b0;
                        mem_en     <= 1'b1;
                    end
                end
                default: begin
                    state  <= BOOT;
                    mem_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
